// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Build option: FETCH_MISALIGN_CHECK_EN enables the misaligned-redirect flag in fetch_unit.
package fetch_pkg;

    localparam int unsigned INST_W           = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StKill
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Word-align a fetch address by clearing the byte-offset bits.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of {pc, inst} pairs with push, pop, flush and occupancy count.
// Head entry is presented combinationally and forced to zero when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  fetch_entry_t    push_entry_i,
    input  logic            pop_i,
    output logic [CntW-1:0] count_o,
    output logic            valid_o,
    output fetch_entry_t    head_o
);

    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && (count_q < DepthCnt);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the count is zero.
    always_ff @(posedge clock_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    always_comb begin
        count_o = count_q;
        valid_o = (count_q != '0);
        head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding an instruction FIFO.
// Build option: FETCH_MISALIGN_CHECK_EN adds a one-cycle flag for unaligned redirect targets.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clock_i,
    input  logic              reset_i,
    output logic              mem_req_o,
    output logic [31:0]       mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [INST_W-1:0] mem_rdata_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [31:0]       inst_pc_o,
    input  logic              inst_ready_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              misalign_o
);

    localparam int unsigned     CntW     = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [CntW-1:0] DepthM1  = CntW'(DEPTH - 1);

    fetch_state_e    state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic [31:0]     redirect_pc;
    logic [31:0]     next_pc;

    logic [CntW-1:0] fifo_count;
    logic            fifo_valid;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_flush;

    // State register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Next-state logic; occupancy is the registered count, so a same-cycle pop
    // only frees room for the decision made on the following cycle.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_addr_d  = req_addr_q;
        redirect_pc = align_pc(redirect_pc_i);
        next_pc     = fetch_pc_q + PC_STEP;
        unique case (state_q)
            StIdle: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                    req_addr_d = redirect_pc;
                    state_d    = StWait;
                end else if (fifo_count < DepthCnt) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                    if (mem_ack_i) begin
                        req_addr_d = redirect_pc;
                        state_d    = StWait;
                    end else begin
                        state_d    = StKill;
                    end
                end else if (mem_ack_i) begin
                    fetch_pc_d = next_pc;
                    if (fifo_count < DepthM1) begin
                        req_addr_d = next_pc;
                        state_d    = StWait;
                    end else begin
                        state_d    = StIdle;
                    end
                end
            end
            StKill: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                    if (mem_ack_i) begin
                        req_addr_d = redirect_pc;
                        state_d    = StWait;
                    end
                end else if (mem_ack_i) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs and FIFO control
    always_comb begin
        mem_req_o = 1'b0;
        fifo_push = 1'b0;
        unique case (state_q)
            StIdle: mem_req_o = 1'b0;
            StWait: begin
                mem_req_o = 1'b1;
                fifo_push = mem_ack_i && !redirect_i;
            end
            StKill: mem_req_o = 1'b1;
            default: mem_req_o = 1'b0;
        endcase
        mem_addr_o      = mem_req_o ? req_addr_q : '0;
        fifo_flush      = redirect_i;
        fifo_pop        = fifo_valid && inst_ready_i;
        push_entry.pc   = fetch_pc_q;
        push_entry.inst = mem_rdata_i;
        inst_valid_o    = fifo_valid;
        inst_o          = fifo_head.inst;
        inst_pc_o       = fifo_head.pc;
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .flush_i      (fifo_flush),
        .push_i       (fifo_push),
        .push_entry_i (push_entry),
        .pop_i        (fifo_pop),
        .count_o      (fifo_count),
        .valid_o      (fifo_valid),
        .head_o       (fifo_head)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder driven from the main flow,
// expected {pc, inst} pairs queued on each kept ack and compared as the core consumes them.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [31:0] EXP_MIS = 32'd1;
`else
    localparam logic [31:0] EXP_MIS = 32'd0;
`endif

    logic              clock = 1'b0;
    logic              reset_i = 1'b1;
    logic              mem_req_o;
    logic [31:0]       mem_addr_o;
    logic              mem_ack_i = 1'b0;
    logic [INST_W-1:0] mem_rdata_i = '0;
    logic              inst_valid_o;
    logic [INST_W-1:0] inst_o;
    logic [31:0]       inst_pc_o;
    logic              inst_ready_i = 1'b0;
    logic              redirect_i = 1'b0;
    logic [31:0]       redirect_pc_i = '0;
    logic              misalign_o;

    int n_vec = 0;
    int n_err = 0;
    fetch_entry_t exp_q[$];

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock_i       (clock),
        .reset_i       (reset_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .misalign_o    (misalign_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0000_0013;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_i      = 1'b1;
        mem_ack_i    = 1'b0;
        redirect_i   = 1'b0;
        inst_ready_i = 1'b0;
        step();
        step();
        reset_i = 1'b0;
        exp_q.delete();
    endtask

    // Acknowledge the outstanding request; keep=1 queues it as an expected instruction.
    task automatic ack_cur(input bit keep);
        fetch_entry_t e;
        check("req_on_ack", 32'(mem_req_o), 32'd1);
        e.pc        = mem_addr_o;
        e.inst      = mem_word(mem_addr_o);
        mem_ack_i   = 1'b1;
        mem_rdata_i = e.inst;
        if (keep) exp_q.push_back(e);
        step();
        mem_ack_i = 1'b0;
    endtask

    // Consumer-side scoreboard: a head presented with ready high is consumed at the next edge.
    always @(negedge clock) begin
        fetch_entry_t e;
        if (!reset_i && inst_valid_o && inst_ready_i) begin
            if (exp_q.size() == 0) begin
                check("spurious_inst_valid", 32'(inst_valid_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("inst_pc", inst_pc_o, e.pc);
                check("inst_word", inst_o, e.inst);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_pc", inst_pc_o, 32'd0);
        check("rst_mis", 32'(misalign_o), 32'd0);
        step();

        // Streaming: ack every cycle, core always ready
        inst_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stream_addr", mem_addr_o, RESET_PC + 32'(i * 4));
            ack_cur(1'b1);
        end
        step();
        step();
        check("stream_drain", 32'(exp_q.size()), 32'd0);

        // Back-pressure: FIFO fills, requests stop, one pop restarts fetch at 0x10
        do_reset();
        step();
        for (int i = 0; i < 4; i++) begin
            check("fill_addr", mem_addr_o, 32'(i * 4));
            ack_cur(1'b1);
        end
        check("full_req", 32'(mem_req_o), 32'd0);
        check("full_valid", 32'(inst_valid_o), 32'd1);
        check("full_head", inst_pc_o, 32'h0);
        step();
        check("full_hold", 32'(mem_req_o), 32'd0);
        inst_ready_i = 1'b1;
        step();
        inst_ready_i = 1'b0;
        check("pop_no_reuse", 32'(mem_req_o), 32'd0);
        step();
        check("refill_req", 32'(mem_req_o), 32'd1);
        check("refill_addr", mem_addr_o, 32'h10);
        check("refill_head", inst_pc_o, 32'h4);

        // Reset in WAIT with acks during and after reset
        reset_i     = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_word(32'h10);
        exp_q.delete();
        step();
        reset_i = 1'b0;
        step();
        mem_ack_i = 1'b0;
        check("rst_ack_valid", 32'(inst_valid_o), 32'd0);
        check("rst_ack_req", 32'(mem_req_o), 32'd1);
        check("rst_ack_addr", mem_addr_o, RESET_PC);

        // Redirect while WAIT at 0x8, ack arrives 3 cycles later and is dropped
        inst_ready_i = 1'b1;
        ack_cur(1'b1);
        ack_cur(1'b1);
        check("pre_redir_addr", mem_addr_o, 32'h8);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        step();
        redirect_i = 1'b0;
        check("kill_addr0", mem_addr_o, 32'h8);
        check("aligned_mis", 32'(misalign_o), 32'd0);
        step();
        check("kill_addr1", mem_addr_o, 32'h8);
        step();
        check("kill_addr2", mem_addr_o, 32'h8);
        ack_cur(1'b0);
        check("post_kill_addr", mem_addr_o, 32'h100);
        check("post_kill_valid", 32'(inst_valid_o), 32'd0);
        ack_cur(1'b1);

        // Redirect coinciding with ack and pop
        mem_ack_i     = 1'b1;
        mem_rdata_i   = mem_word(32'h104);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        step();
        mem_ack_i  = 1'b0;
        redirect_i = 1'b0;
        check("coinc_valid", 32'(inst_valid_o), 32'd0);
        check("coinc_inst", inst_o, 32'd0);
        check("coinc_pc", inst_pc_o, 32'd0);
        check("coinc_req", 32'(mem_req_o), 32'd1);
        check("coinc_addr", mem_addr_o, 32'h200);
        ack_cur(1'b1);

        // Unaligned redirect target
        mem_ack_i     = 1'b1;
        mem_rdata_i   = mem_word(32'h204);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h202;
        step();
        mem_ack_i  = 1'b0;
        redirect_i = 1'b0;
        check("mis_flag", 32'(misalign_o), EXP_MIS);
        check("mis_addr", mem_addr_o, 32'h200);
        step();
        check("mis_clear", 32'(misalign_o), 32'd0);
        ack_cur(1'b1);

        // Redirects while in KILL keep the old address until its ack
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h300;
        step();
        check("kill2_addr0", mem_addr_o, 32'h204);
        redirect_pc_i = 32'h400;
        step();
        redirect_i = 1'b0;
        check("kill2_addr1", mem_addr_o, 32'h204);
        ack_cur(1'b0);
        check("kill2_new", mem_addr_o, 32'h400);

        // Redirect from IDLE with a full FIFO; fetch_pc wraps modulo 2^32
        inst_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("fill2_addr", mem_addr_o, 32'h400 + 32'(i * 4));
            ack_cur(1'b0);
        end
        check("fill2_idle", 32'(mem_req_o), 32'd0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        check("idle_redir_valid", 32'(inst_valid_o), 32'd0);
        check("idle_redir_req", 32'(mem_req_o), 32'd1);
        check("idle_redir_addr", mem_addr_o, 32'hFFFF_FFFC);
        inst_ready_i = 1'b1;
        ack_cur(1'b1);
        check("wrap_addr", mem_addr_o, 32'h0);
        ack_cur(1'b1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        check("final_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction FIFO entries (power of 2, min 2).
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000: first fetch address after reset.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clock_i  in  1  sole clock, all state on rising edge.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 mem_req_o  out  1  instruction-memory request, held until mem_ack_i.
REQ-007 mem_addr_o  out  32  word-aligned fetch address, stable while mem_req_o=1.
REQ-008 mem_ack_i  in  1  response strobe, one cycle per request.
REQ-009 mem_rdata_i  in  32  instruction word, valid when mem_ack_i=1.
REQ-010 inst_valid_o  out  1  FIFO head holds an instruction.
REQ-011 inst_o  out  32  head instruction word.
REQ-012 inst_pc_o  out  32  address of inst_o.
REQ-013 inst_ready_i  in  1  core consumes head this cycle.
REQ-014 redirect_i  in  1  branch/jump taken; flush and refetch.
REQ-015 redirect_pc_i  in  32  new fetch address, sampled when redirect_i=1.
REQ-016 misalign_o  out  1  one-cycle flag: redirect target not word aligned.

Function
REQ-017 SHALL use FSM states IDLE (no request), WAIT (request outstanding), KILL (outstanding request to be discarded).
REQ-018 IDLE: if count<DEPTH, next cycle enter WAIT with mem_addr_o=fetch_pc, mem_req_o=1.
REQ-019 mem_req_o SHALL be 1 exactly in WAIT and KILL; at most one request outstanding.
REQ-020 WAIT+ack: push {fetch_pc, mem_rdata_i}, fetch_pc+=4 (mod 2^32); stay WAIT with new address if post-push count<DEPTH, else IDLE.
REQ-021 Pop SHALL occur when inst_valid_o&&inst_ready_i; space freed by a same-cycle pop not used for the push decision until next cycle.
REQ-022 inst_valid_o=(count!=0); inst_o/inst_pc_o = head entry, 0 when empty; zero-cycle combinational path from FIFO to outputs.
REQ-023 Redirect SHALL flush FIFO (count=0), load fetch_pc={redirect_pc_i[31:2],2'b00}; overrides same-cycle pop and push.
REQ-024 Redirect in WAIT without ack -> KILL, mem_addr_o holds old address until ack.
REQ-025 Redirect in WAIT with same-cycle ack -> data discarded, WAIT with new address next cycle.
REQ-026 KILL+ack -> data discarded, enter WAIT with fetch_pc; redirect in KILL updates fetch_pc, stays KILL (or WAIT if same-cycle ack).
REQ-027 Redirect in IDLE -> WAIT next cycle at new address.
REQ-028 Fill latency: redirect at cycle N, mem ack at N+k -> inst_valid_o at N+k+1.

Reset
REQ-029 Reset SHALL set state IDLE, fetch_pc=RESET_PC, count=0, mem_req_o=0, mem_addr_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, misalign_o=0.
REQ-030 Reset mid-request SHALL abandon it; an ack arriving in IDLE SHALL be ignored.

Configuration
REQ-031 Macro FETCH_MISALIGN_CHECK_EN defined: misalign_o=1 cycle after redirect with redirect_pc_i[1:0]!=0, else 0.
REQ-032 Macro undefined: misalign_o tied 0, no check logic; low-bit clearing of REQ-023 unchanged.

Structure
REQ-033 Package fetch_pkg SHALL hold FSM state enum, INST_W=32, PC_STEP=4, default RESET_PC.
REQ-034 Sub-module fetch_fifo SHALL implement the DEPTH-entry {pc,inst} FIFO with push, pop, flush, count; fetch_unit holds FSM and fetch_pc.

Verification
REQ-035 Reset, ack every cycle, ready=1: mem_addr_o 0x0,0x4,0x8; inst_pc_o sequence 0x0,0x4,0x8 with matching words.
REQ-036 ready=0, DEPTH=4: after 4 acks count=4, mem_req_o=0, state IDLE; ready=1 one cycle -> new request at 0x10.
REQ-037 Redirect to 0x100 while WAIT at 0x8, ack 3 cycles later: word from 0x8 dropped, next request 0x100, inst_pc_o=0x100.
REQ-038 Redirect to 0x200 coinciding with ack and pop: FIFO empty next cycle, mem_addr_o=0x200, no stale inst_valid_o.
REQ-039 FETCH_MISALIGN_CHECK_EN, redirect to 0x202: misalign_o=1 one cycle, mem_addr_o=0x200; without macro misalign_o=0.
REQ-040 Reset asserted in WAIT, ack during reset and next cycle: FIFO empty, next request at RESET_PC.
